seq_arith_iter_rotator: RTL
===========================

# seq_arith_iter_rotator

Iterative, multi-cycle rotator with a latency-insensitive val/rdy request/response interface. It accepts a data word, rotate amount and direction, rotates one bit position per cycle, and then holds the result until the consumer takes it. It is the sequential, handshaked counterpart of the combinational 8-bit rotator in the arithmetic block family. Its bit-exact behaviour matches that combinational rotator, so the same golden model checks both.

## Interface
- p_nbits, default 8: data width; must be a power of two, ≥ 2.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 resets immediately, released synchronously to clk.
- req_val  input  1  request valid.
- req_rdy  output  1  request ready; high only in IDLE.
- req_in_  input  p_nbits  data to rotate.
- req_amt  input  $clog2(p_nbits)  rotate amount, 0..p_nbits-1.
- req_op  input  1  0 = rotate left, 1 = rotate right.
- resp_val  output  1  response valid; high only in DONE.
- resp_rdy  input  1  response ready.
- resp_msg  output  p_nbits  rotated result; driven from the data register at all times.

## Operation
- Registers:
  - state: IDLE, CALC or DONE.
  - data: p_nbits bits.
  - count: $clog2(p_nbits) bits.
  - iter: $clog2(p_nbits) bits; used only by the fixed-latency build.
  - op: 1 bit.
- IDLE: req_rdy=1. On req_val=1 at an edge, latch req_in_ into data, req_amt into count and req_op into op, and clear iter.
  - Next state is CALC.
  - Exception: with the early-exit macro and req_amt==0, next state is DONE.
- CALC: req_rdy=0, resp_val=0. Each edge:
  - If count≠0, data rotates one position and count decrements.
    - op=0: data ← {data[p_nbits-2:0], data[p_nbits-1]}.
    - op=1: data ← {data[0], data[p_nbits-1:1]}.
  - If count==0, data holds.
  - Exit to DONE is set by the configuration (see Configuration).
- DONE: resp_val=1 and resp_msg=data.
  - On resp_rdy=1 at an edge, go to IDLE.
  - Otherwise data, resp_msg and resp_val hold indefinitely.
- No request is accepted in DONE, so there is no same-cycle response/request overlap.
- Inputs req_in_, req_amt and req_op are ignored outside the accepting edge. Changing them mid-operation has no effect.
- Result is always in_ rotated by amt modulo p_nbits. amt=0 returns in_ unchanged.

## Timing
- Reset (async assert):
  - state=IDLE, data=0, count=0, iter=0.
  - req_rdy=1, resp_val=0, resp_msg=0.
- Reset asserted mid-CALC or in DONE aborts the operation immediately. The pending result is discarded and no response is issued.
- Acceptance edge = edge E with req_val & req_rdy. resp_val rises in the cycle after edge E+L, where L is the configured latency.
- Minimum occupancy per transaction is L+2 cycles: L CALC edges, one DONE edge with resp_rdy=1, then IDLE.
- All outputs are registered-state functions (Moore). There are no combinational paths from req_val or resp_rdy to any output.

## Configuration
- Macro: SEQ_ARITH_ITER_ROTATOR_EARLY_EXIT_EN.
- Undefined (default): fixed latency.
  - CALC always lasts exactly p_nbits-1 edges, tracked by iter incrementing each CALC edge; exit when iter==p_nbits-2.
  - Rotation stops once count==0.
  - L = p_nbits-1 = 7 for the default width, regardless of amt.
- Defined: variable latency.
  - CALC exits on the edge where count goes 1→0.
  - amt==0 goes IDLE→DONE directly.
  - L = amt (amt==0 → L=0, so resp_val is high the cycle after acceptance).
- Result values are identical in both builds. Only the latency differs.

## Test plan
- Left rotate: in_=0x5D, amt=3, op=0, resp_rdy=1 → resp_msg=0xEA.
  - resp_val rises in the cycle after edge E+7 (macro off) or edge E+3 (macro on).
- Right rotate: in_=0xD5, amt=2, op=1 → resp_msg=0x75.
  - Sweep amt 0..7 for both 0x5D/op=0 and 0xD5/op=1, comparing against the combinational golden model.
- Zero amount: in_=0xA3, amt=0 → resp_msg=0xA3.
  - Latency 7 with macro off; resp_val the next cycle with macro on.
- Backpressure: hold resp_rdy=0 for 5 cycles after resp_val rises.
  - resp_val, resp_msg and req_rdy=0 remain stable.
  - A req_val pulse in that window is not accepted.
  - resp_rdy=1 → IDLE next cycle with req_rdy=1.
- Reset mid-operation: accept 0xFF/amt=5, assert reset=0 after 2 CALC cycles.
  - Outputs immediately read req_rdy=1, resp_val=0, resp_msg=0.
  - After release, a new request 0x01/amt=1/op=1 → 0x80.
- Random: 20 random (in_, amt, op) requests with random resp_rdy stalls.
  - Every response matches the golden model in order, with exactly one response per accepted request.

Source files
------------

// File: rtl/seq_arith_iter_rotator.sv
// Iterative val/rdy rotator: one bit position per CALC cycle, result held in DONE.
// Define SEQ_ARITH_ITER_ROTATOR_EARLY_EXIT_EN for latency = amt instead of p_nbits-1.
module seq_arith_iter_rotator #(
    parameter int p_nbits = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_val,
    output logic                         req_rdy,
    input  logic [p_nbits-1:0]           req_in_,
    input  logic [$clog2(p_nbits)-1:0]   req_amt,
    input  logic                         req_op,
    output logic                         resp_val,
    input  logic                         resp_rdy,
    output logic [p_nbits-1:0]           resp_msg
);

    localparam int AW = $clog2(p_nbits);
    localparam logic [AW-1:0] ONE       = AW'(1);
    localparam logic [AW-1:0] ITER_LAST = AW'(p_nbits - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_n;
    logic [p_nbits-1:0]   data;
    logic [AW-1:0]        count;
    logic [AW-1:0]        iter;
    logic                 op;
    logic                 calc_last;

`ifdef SEQ_ARITH_ITER_ROTATOR_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
    assign calc_last = (count == ONE);
`else
    localparam bit EARLY = 1'b0;
    assign calc_last = (iter == ITER_LAST);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            data  <= '0;
            count <= '0;
            iter  <= '0;
            op    <= 1'b0;
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: begin
                    if (req_val) begin
                        data  <= req_in_;
                        count <= req_amt;
                        op    <= req_op;
                        iter  <= '0;
                    end
                end
                CALC: begin
                    if (count != '0) begin
                        if (op)
                            data <= {data[0], data[p_nbits-1:1]};
                        else
                            data <= {data[p_nbits-2:0], data[p_nbits-1]};
                        count <= count - ONE;
                    end
                    iter <= iter + ONE;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n  = state;
        req_rdy  = 1'b0;
        resp_val = 1'b0;
        unique case (state)
            IDLE: begin
                req_rdy = 1'b1;
                if (req_val)
                    state_n = (EARLY && req_amt == '0) ? DONE : CALC;
            end
            CALC: begin
                if (calc_last)
                    state_n = DONE;
            end
            DONE: begin
                resp_val = 1'b1;
                if (resp_rdy)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign resp_msg = data;

endmodule
